// File: rtl/tx_pkg.sv
// tx_pkg: frame geometry shared with the transmitter and scheduler state encoding
package tx_pkg;
    localparam int PAYLOAD_BYTES  = 1024;
    localparam int OFS_W          = $clog2(PAYLOAD_BYTES);
    localparam int PREAMBLE_BYTES = 8;
    localparam int HEADER_BYTES   = 16;
    localparam int CRC_BYTES      = 4;
    localparam int FRAME_BYTES    = PREAMBLE_BYTES + HEADER_BYTES + PAYLOAD_BYTES + CRC_BYTES;
    localparam int IFG            = 16;
    localparam int LAUNCH_TO      = 16;
    localparam int CNT_W          = 5;
    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} tx_state_e;
endpackage

// File: rtl/tx_fill.sv
// tx_fill: writes the producer byte stream into alternating payload banks
module tx_fill
    import tx_pkg::*;
(
    input  logic             clk125,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    input  logic [1:0]       bank_full,
    output logic             in_ready,
    output logic             wr_en,
    output logic [OFS_W:0]   wr_addr,
    output logic [7:0]       wr_data,
    output logic [1:0]       fill_done,
    output logic [15:0]      drop_cnt
);
    logic             bank;
    logic [OFS_W-1:0] ofs;
    logic             accept, last;

    assign in_ready  = !bank_full[bank];
    assign accept    = in_valid && in_ready;
    assign last      = ofs == OFS_W'(PAYLOAD_BYTES - 1);
    assign fill_done = {2{accept && last}} & (bank ? 2'b10 : 2'b01);

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            bank     <= 1'b0;
            ofs      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            drop_cnt <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= {bank, ofs};
                wr_data <= in_data;
                ofs     <= ofs + 1'b1;
                bank    <= bank ^ last;
            end
            if (in_valid && !in_ready && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/tx_sched.sv
// tx_sched: ping-pong payload scheduler launching full banks to the RGMII transmitter
module tx_sched
    import tx_pkg::*;
(
    input  logic        clk125,
    input  logic        rst_n,
    input  logic        en,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        idx,
    input  logic        txctl,
    output logic [1:0]  bank_full,
    output logic [15:0] frames_sent,
    output logic [15:0] drop_cnt,
    output logic        err_timeout
);
    tx_state_e        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             txctl_q, launch, sent, abandon;
    logic [1:0]       fill_done, clr;

    tx_fill u_fill (
        .clk125    (clk125),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .bank_full (bank_full),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .fill_done (fill_done),
        .drop_cnt  (drop_cnt)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        launch  = 1'b0;
        sent    = 1'b0;
        abandon = 1'b0;
        case (state)
            IDLE:   if (en && bank_full[~idx]) begin
                        launch  = 1'b1;
                        cnt_d   = CNT_W'(LAUNCH_TO);
                        state_d = LAUNCH;
                    end
            LAUNCH: if (txctl_q) state_d = BUSY;
                    else if (cnt == CNT_W'(1)) begin
                        abandon = 1'b1;
                        cnt_d   = CNT_W'(IFG);
                        state_d = GAP;
                    end else cnt_d = cnt - 1'b1;
            BUSY:   if (!txctl_q) begin
                        sent    = 1'b1;
                        cnt_d   = CNT_W'(IFG);
                        state_d = GAP;
                    end
            GAP:    if (txctl_q) cnt_d = CNT_W'(IFG);
                    else if (cnt == CNT_W'(1)) state_d = IDLE;
                    else cnt_d = cnt - 1'b1;
            default: state_d = IDLE;
        endcase
    end

    // The sending bank is released whether the frame went out or was abandoned
    assign clr = {2{sent || abandon}} & (idx ? 2'b10 : 2'b01);

    always_ff @(posedge clk125 or negedge rst_n) begin
        if (!rst_n) begin
            txctl_q     <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= 1'b1;
            bank_full   <= 2'b00;
            frames_sent <= '0;
            err_timeout <= 1'b0;
        end else begin
            txctl_q     <= txctl;
            state       <= state_d;
            cnt         <= cnt_d;
            idx         <= idx ^ launch;
            bank_full   <= (bank_full | fill_done) & ~clr;
            frames_sent <= frames_sent + 16'(sent);
            err_timeout <= err_timeout | abandon;
        end
    end
endmodule
